// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and encoder for the switch/digit display.
// Segments are active-low: bit 7 = DP, bits 6:0 = g..a.
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam int         SEG_DP_BIT = 7;

  localparam logic [7:0] SEG_DIGIT [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  // Maps a 4-bit value to its digit pattern (DP off); non-decimal values blank.
  function automatic logic [7:0] seg_pattern(input logic [3:0] value);
    logic [7:0] pattern;
    case (value)
      4'd0:    pattern = SEG_DIGIT[0];
      4'd1:    pattern = SEG_DIGIT[1];
      4'd2:    pattern = SEG_DIGIT[2];
      4'd3:    pattern = SEG_DIGIT[3];
      4'd4:    pattern = SEG_DIGIT[4];
      4'd5:    pattern = SEG_DIGIT[5];
      4'd6:    pattern = SEG_DIGIT[6];
      4'd7:    pattern = SEG_DIGIT[7];
      4'd8:    pattern = SEG_DIGIT[8];
      4'd9:    pattern = SEG_DIGIT[9];
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/switch_debouncer.sv
// One switch channel: 2-flop synchroniser followed by a persistence counter.
// A new level is accepted only after DEBOUNCE_CYCLES consecutive mismatching
// cycles; any return to the accepted level restarts the count.
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic stable,
  output logic pending,
  output logic rise
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] cnt;

  logic          accept;

  // Acceptance happens on the cycle the counter sits at its last value while
  // the synchronised level still disagrees with the accepted one.
  assign accept  = (sync_2 != stable) && (cnt == CNT_LAST);
  assign rise    = accept && sync_2;
  assign pending = (cnt != '0);

  // Synchroniser, persistence counter and accepted level.
  // NOTE: all state here updates with <= so every flop samples pre-edge values;
  // blocking assignments would collapse the two synchroniser stages into one.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      if (sync_2 == stable) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= sync_2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_digit_display.sv
// Switch -> LED / 7-segment display block. Each channel is debounced; its LED
// shows the accepted level and its digit shows either that level or a BCD
// count of accepted switch-up events. DP is lit while a change is settling.
module switch_digit_display
  import seg7_pkg::*;
#(
  parameter int CHANNELS        = 6,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [CHANNELS-1:0]   SW,
  input  logic                  mode,
  input  logic                  count_clear,
  output logic [CHANNELS-1:0]   LEDR,
  output logic [8*CHANNELS-1:0] HEX
);

  logic [CHANNELS-1:0] stable;
  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] rise;

  logic [3:0] upcount [CHANNELS];
  logic [7:0] hex_q   [CHANNELS];
  logic [7:0] hex_d   [CHANNELS];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    switch_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clock  (clock),
      .reset_n(reset_n),
      .raw    (SW[i]),
      .stable (stable[i]),
      .pending(pending[i]),
      .rise   (rise[i])
    );

    assign HEX[8*i +: 8] = hex_q[i];
  end

  assign LEDR = stable;

  // Next digit image per channel: selected source pattern with DP = ~pending.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      hex_d[i] = mode ? seg_pattern(upcount[i]) : seg_pattern({3'b000, stable[i]});
      hex_d[i][SEG_DP_BIT] = ~pending[i];
    end
  end

  // Up-counters (clear beats increment) and registered HEX digits.
  // NOTE: the counters are a handful of flops, so resetting them is cheap and
  // keeps the display deterministic from the first edge after reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        upcount[i] <= 4'd0;
        hex_q[i]   <= SEG_BLANK;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (count_clear) begin
          upcount[i] <= 4'd0;
        end else if (rise[i]) begin
          upcount[i] <= (upcount[i] == 4'd9) ? 4'd0 : upcount[i] + 4'd1;
        end
        hex_q[i] <= hex_d[i];
      end
    end
  end

endmodule

// File: doc/switch_digit_display.md
Name: switch_digit_display

Overview:
Parametrised, clocked successor to the switch-to-LED/7-segment display block. Each of CHANNELS slide switches is synchronised and debounced. The debounced state drives one LED. The same channel's 7-segment digit shows either the switch state (0/1) or a per-channel count of switch-up events (0-9). The block sits at top level between board switches, LEDR and HEX digits.

Parameters:
CHANNELS, 6, number of switch/LED/digit channels (legal 1..6)
DEBOUNCE_CYCLES, 500000, consecutive clock cycles a new switch level must persist before acceptance (10 ms at 50 MHz; legal >= 1)

Ports:
clock  input  1  system clock (50 MHz)
reset_n  input  1  synchronous active-low reset
SW  input  CHANNELS  raw asynchronous switch levels, 1 = up
mode  input  1  0 = digits show debounced state; 1 = digits show per-channel up-count
count_clear  input  1  synchronous clear of all up-counters, level-sensitive
LEDR  output  CHANNELS  debounced switch state, 1 = lit
HEX  output  8*CHANNELS  digit i on HEX[8i+7:8i], active-low segments; bit 7 = DP, bits 6:0 = g..a

Behaviour:
- Interface fixed: one clock (clock); reset is synchronous and active-low (reset_n), sampled on the rising edge of clock.
- Reset (reset_n = 0 at an edge):
  - Synchroniser flops = 0.
  - Debounced state = 0; LEDR = 0.
  - Debounce counters = 0.
  - Up-counters = 0.
  - Every HEX digit = 8'hFF (blank).
  - Asserting reset mid-debounce discards the pending change.
- Synchronisation:
  - 2-flop synchroniser per channel.
  - sync_i lags SW[i] by 2 edges.
- Debounce, per channel:
  - Signals: stable_i (register), cnt_i (width $clog2(DEBOUNCE_CYCLES+1)).
  - sync_i == stable_i: cnt_i <= 0.
  - sync_i != stable_i and cnt_i < DEBOUNCE_CYCLES-1: cnt_i <= cnt_i+1.
  - sync_i != stable_i and cnt_i == DEBOUNCE_CYCLES-1: stable_i <= sync_i, cnt_i <= 0.
  - A bounce back to the old level before acceptance resets cnt_i. No change is accepted.
  - Clean-edge latency: SW change to stable_i change = DEBOUNCE_CYCLES+2 edges.
  - DEBOUNCE_CYCLES = 1: acceptance on the first mismatching cycle.
  - pending_i = (cnt_i != 0).
- LEDR[i] = stable_i, driven directly from the register with no extra delay.
- Up-counter, per channel:
  - 4-bit BCD, 0..9.
  - Increments on a stable_i 0->1 transition, i.e. the cycle stable_i is written from 0 to 1.
  - 9 wraps to 0.
  - 1->0 transitions do not count.
  - count_clear = 1: all counters <= 0. Clear wins over a same-cycle increment.
- HEX, registered, 1 cycle after its sources:
  - Segments: mode 0 shows pattern(stable_i); mode 1 shows pattern(upcount_i).
  - DP bit 7 = ~pending_i, so DP is lit while a change is settling.
  - A mode change takes effect on HEX the following edge and does not disturb counters or debounce.
- Channels are fully independent. Simultaneous changes on several channels are handled in parallel with identical latency.

Decomposition:
- Package seg7_pkg:
  - SEG_BLANK = 8'hFF.
  - SEG_DIGIT[0:9] = C0, F9, A4, B0, 99, 92, 82, F8, 80, 90 (DP off).
  - SEG_DP_BIT = 7.
  - Function returning the 8-bit pattern for a 4-bit value.
- One sub-module, switch_debouncer (parameter DEBOUNCE_CYCLES):
  - Ports: clock, reset_n, raw, stable, pending. Contains synchroniser and counter.
  - Instantiated CHANNELS times via generate.
  - Up-counters and HEX registers live in the top module.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, CHANNELS=6.
1. Reset, SW=0: hold reset_n=0 for 3 edges, then release -> during reset LEDR=0, HEX all 8'hFF; 1 edge after release every digit = 8'hC0.
2. Clean switch-up: SW[2] 0->1 held -> LEDR[2]=1 exactly 6 edges later; HEX[23:16] = 8'hF9 one edge after that; DP (HEX[23]) low on the edges while cnt!=0.
3. Bounce: SW[0] toggles 1,0,1 every 2 cycles, then holds 1 -> no LEDR[0] change until 6 edges after the final rise.
4. Up-count wrap, mode=1: 10 clean up/down cycles on SW[5] -> HEX[47:40] walks F9, A4, ..., 90, then C0 after the 10th rise; other digits stay C0.
5. Clear vs increment: count_clear=1 on the same edge SW[1] is accepted high -> upcount_1=0, HEX shows C0 in mode 1 while LEDR[1]=1.
6. Reset mid-debounce: reset_n=0 when cnt=2 on channel 3 -> after release LEDR[3]=0, DP high; if SW[3] is still 1, acceptance occurs 6 edges after release.
